// File: rtl/aes128_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_decrypt_iter
// Iterative AES-128 decryptor: one inverse round per clock. Round keys are
// derived on the fly, first by running the forward expansion up to rk10 and
// then by stepping the inverse key schedule back down to rk0.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   in_valid     cipher_text/key valid
//   in_ready     block can accept a new job (IDLE)
//   cipher_text  128-bit ciphertext, byte 0 = [127:120]
//   key          128-bit cipher key, same byte order
//   out_valid    plain_text valid
//   out_ready    downstream accepts plain_text
//   plain_text   decrypted block, held stable while out_valid=1
//   busy         high during key expansion or inverse rounds
//
// Optional feature: define AES128_DECRYPT_KEYCACHE_EN to keep the rk10 of the
// most recent key so a repeated key skips the forward expansion.
// ---------------------------------------------------------------------------
module aes128_decrypt_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_text,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  // ---------------- GF(2^8) and S-box helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  // ---------------- key schedule ----------------
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo key_exp: the last three words fall out by XOR, which exposes the
  // previous w3 needed to strip the g() term from w0.
  function automatic logic [127:0] inv_key_exp(input logic [127:0] n, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = n[31:0]  ^ n[63:32];
    w2 = n[63:32] ^ n[95:64];
    w1 = n[95:64] ^ n[127:96];
    w0 = n[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- inverse round transforms ----------------
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return o;
  endfunction

  // ---------------- datapath / FSM ----------------
  state_t       st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] kreg_q, kreg_d;
  logic [127:0] sreg_q, sreg_d;
  logic [127:0] pt_q, pt_d;
  logic         ov_q, ov_d;
  logic [127:0] kexp_nxt, rk_inv, round_nomix;
`ifdef AES128_DECRYPT_KEYCACHE_EN
  logic [127:0] last_key_q, last_key_d;
  logic [127:0] cache_q, cache_d;
  logic         cv_q, cv_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      kreg_q <= '0;
      sreg_q <= '0;
      pt_q   <= '0;
      ov_q   <= 1'b0;
`ifdef AES128_DECRYPT_KEYCACHE_EN
      last_key_q <= '0;
      cache_q    <= '0;
      cv_q       <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      kreg_q <= kreg_d;
      sreg_q <= sreg_d;
      pt_q   <= pt_d;
      ov_q   <= ov_d;
`ifdef AES128_DECRYPT_KEYCACHE_EN
      last_key_q <= last_key_d;
      cache_q    <= cache_d;
      cv_q       <= cv_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    kreg_d = kreg_q;
    sreg_d = sreg_q;
    pt_d   = pt_q;
    ov_d   = ov_q;
`ifdef AES128_DECRYPT_KEYCACHE_EN
    last_key_d = last_key_q;
    cache_d    = cache_q;
    cv_d       = cv_q;
`endif
    kexp_nxt    = key_exp(kreg_q, rcon(cnt_q));
    rk_inv      = inv_key_exp(kreg_q, rcon(cnt_q + 4'd1));
    round_nomix = inv_sub_bytes(inv_shift_rows(sreg_q)) ^ rk_inv;

    case (st_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d = cipher_text;
          kreg_d = key;
          cnt_d  = 4'd1;
          st_d   = KEXP;
`ifdef AES128_DECRYPT_KEYCACHE_EN
          if (cv_q && key == last_key_q) begin
            kreg_d = cache_q;
            sreg_d = cipher_text ^ cache_q;
            cnt_d  = 4'd9;
            st_d   = ROUND;
          end else begin
            // Key recorded now (it is only valid on this edge); the cache
            // becomes valid once rk10 for it has been produced.
            last_key_d = key;
            cv_d       = 1'b0;
          end
`endif
        end
      end
      KEXP: begin
        kreg_d = kexp_nxt;
        if (cnt_q == 4'd10) begin
          sreg_d = sreg_q ^ kexp_nxt;
          cnt_d  = 4'd9;
          st_d   = ROUND;
`ifdef AES128_DECRYPT_KEYCACHE_EN
          cache_d = kexp_nxt;
          cv_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        kreg_d = rk_inv;
        if (cnt_q != 4'd0) begin
          sreg_d = inv_mix_columns(round_nomix);
          cnt_d  = cnt_q - 4'd1;
        end else begin
          sreg_d = round_nomix;
          pt_d   = round_nomix;
          ov_d   = 1'b1;
          st_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign in_ready   = (st_q == IDLE);
  assign busy       = (st_q == KEXP) || (st_q == ROUND);
  assign out_valid  = ov_q;
  assign plain_text = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
module tb_aes128_decrypt_iter;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES128_DECRYPT_KEYCACHE_EN
  localparam int HIT_LAT = 10;
`else
  localparam int HIT_LAT = 20;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] cipher_text = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plain_text;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  aes128_decrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cipher_text(cipher_text),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plain_text (plain_text),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [127:0] k, input logic [127:0] ct, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready_before"}, 128'(in_ready), 128'(1'b1));
    in_valid    = 1'b1;
    cipher_text = ct;
    key         = k;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, 128'(busy), 128'(1'b1));
    chk({tag, "_in_ready_after_accept"}, 128'(in_ready), 128'(1'b0));
  endtask

  // Accepts a job, counts edges until out_valid, checks latency and result.
  task automatic run(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] exp_pt,
                     input int exp_lat, input bit check_rk, input bit toggle, input string tag);
    int lat;
    accept(k, ct, tag);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (check_rk && lat == 10) chk({tag, "_rk10"}, dut.kreg_q, C1_RK10);
      if (out_valid) break;
      if (toggle) begin
        in_valid    = 1'($urandom_range(0, 1));
        cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_plain_text"}, plain_text, exp_pt);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_dropped"}, 128'(out_valid), 128'(1'b0));
    chk({tag, "_in_ready_back"}, 128'(in_ready), 128'(1'b1));
  endtask

  initial begin
    bit saw_ov;

    // Reset state, checked before any clock edge.
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_plain_text", plain_text, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 C.1
    run(C1_KEY, C1_CT, C1_PT, 20, 1'b1, 1'b0, "c1");
    drain("c1");

    // FIPS-197 App.B with back-pressure
    run(B_KEY, B_CT, B_PT, 20, 1'b0, 1'b0, "appb");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("appb_hold_pt", plain_text, B_PT);
      chk("appb_hold_ov", 128'(out_valid), 128'(1'b1));
      chk("appb_hold_in_ready", 128'(in_ready), 128'(1'b0));
    end
    drain("appb");

    // Reset in ROUND with cnt=4 (15 edges after accept)
    accept(C1_KEY, C1_CT, "midrst");
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("midrst_cnt", 128'(dut.cnt_q), 128'(4'd4));
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    chk("midrst_plain_text", plain_text, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_ov = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    chk("midrst_no_output", 128'(saw_ov), 128'(1'b0));
    run(B_KEY, B_CT, B_PT, 20, 1'b0, 1'b0, "postrst");
    drain("postrst");

    // Inputs toggled during operation must be ignored (same key as before)
    run(B_KEY, B_CT, B_PT, HIT_LAT, 1'b0, 1'b1, "toggle");
    drain("toggle");

    // Back-to-back C.1, then App.B
    run(C1_KEY, C1_CT, C1_PT, 20, 1'b1, 1'b0, "c1_first");
    drain("c1_first");
    run(C1_KEY, C1_CT, C1_PT, HIT_LAT, 1'b0, 1'b0, "c1_second");
    drain("c1_second");
    run(B_KEY, B_CT, B_PT, 20, 1'b0, 1'b0, "appb_miss");
    drain("appb_miss");

    // out_ready held high: DONE lasts a single cycle
    out_ready = 1'b1;
    run(B_KEY, B_CT, B_PT, HIT_LAT, 1'b0, 1'b0, "rdy_held");
    @(negedge clk);
    chk("rdy_held_ov_one_cycle", 128'(out_valid), 128'(1'b0));
    chk("rdy_held_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
